ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_iter_core.sv | 61 ++++++
 rtl/ex_muldiv.sv | 181 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants and types for the EX-stage multiply/divide unit
//
// Holds the funct3 op encodings, the FSM state type, the iteration counts for
// full-width and W-variant ops, and a 32->64 sign-extension helper.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // Iteration counts: one bit of multiplier / dividend per CALC cycle.
  localparam logic [6:0] ITER_D = 7'd64;
  localparam logic [6:0] ITER_W = 7'd32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - shared 128-bit shift-add multiply / restoring divide datapath
//
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   load        capture operand magnitudes and op kind, clear the upper half
//   step        perform one iteration
//   is_div      op kind sampled on load (1 = divide, 0 = multiply)
//   word        W-variant, sampled on load (positions a 32-bit dividend)
//   a_in, b_in  magnitudes: multiplier/dividend and multiplicand/divisor
//   acc         {high, low}: product, or {remainder, quotient}
module muldiv_iter_core
  import muldiv_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         step,
  input  logic         is_div,
  input  logic         word,
  input  logic [63:0]  a_in,
  input  logic [63:0]  b_in,
  output logic [127:0] acc
);

  logic [63:0] b_q;
  logic        div_q;
  logic [64:0] mul_sum;
  logic [64:0] div_trial;
  logic [64:0] div_diff;

  always_comb begin
    // Multiply consumes the multiplier from the LSB of the low half.
    mul_sum   = {1'b0, acc[127:64]} + (acc[0] ? {1'b0, b_q} : 65'd0);
    // Divide: partial remainder shifted left with the next dividend bit.
    // It is always below 2*divisor, so bit 64 of the difference is a clean borrow.
    div_trial = acc[127:63];
    div_diff  = div_trial - {1'b0, b_q};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc   <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      b_q   <= b_in;
      div_q <= is_div;
      // A 32-bit dividend is placed at the top of the low half so MSB-first
      // shifting reaches it after 32 steps.
      acc   <= {64'd0, (is_div && word) ? {a_in[31:0], 32'd0} : a_in};
    end else if (step) begin
      if (div_q) begin
        if (!div_diff[64]) acc <= {div_diff[63:0], acc[62:0], 1'b1};
        else               acc <= {acc[126:0], 1'b0};
      end else begin
        acc <= {mul_sum, acc[63:1]};
      end
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - RV64 M-extension multiply/divide unit for the EX stage
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start                op request from EX (accepted only when idle)
//   funct3, word         op select and W-variant flag
//   rs1_val, rs2_val     operands
//   rd_in                destination tag
//   flush                abort the op in flight, no done pulse
//   busy                 op in progress (CALC, FIX, DONE)
//   done                 one-cycle result-valid pulse
//   result, rd_out       result and tag, held until the next done
//   stall_req            freeze request to the hazard unit
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic        word,
  input  logic [63:0] rs1_val,
  input  logic [63:0] rs2_val,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic [4:0]  rd_out,
  output logic        stall_req
);

  state_t       state;
  logic         fix_ph;
  logic [6:0]   cnt;
  logic [2:0]   f3_q;
  logic         word_q;
  logic [4:0]   rd_q;
  logic         neg_q;
  logic         spec_q;
  logic [63:0]  spec_val_q;
  logic [127:0] fix_q;

  logic         in_div, in_sa, in_sb, in_illegal, in_dz, in_ovf, in_spec, in_neg;
  logic         a_neg, b_neg;
  logic [63:0]  in_a, in_b, a_mag, b_mag, in_spec_val;
  logic         accept, core_load;
  logic [127:0] core_acc, raw;
  logic         hi_sel;
  logic [63:0]  sel;

  // Operand decode on the request inputs so the core loads on the accepting edge.
  always_comb begin
    in_div     = (funct3 == OP_DIV) || (funct3 == OP_DIVU) ||
                 (funct3 == OP_REM) || (funct3 == OP_REMU);
    in_sa      = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                 (funct3 == OP_DIV)  || (funct3 == OP_REM);
    in_sb      = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
    in_illegal = word && ((funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                          (funct3 == OP_MULHU));
    if (word) begin
      in_a = in_sa ? sext32(rs1_val[31:0]) : {32'd0, rs1_val[31:0]};
      in_b = in_sb ? sext32(rs2_val[31:0]) : {32'd0, rs2_val[31:0]};
    end else begin
      in_a = rs1_val;
      in_b = rs2_val;
    end
    a_neg  = in_sa && in_a[63];
    b_neg  = in_sb && in_b[63];
    a_mag  = a_neg ? (64'd0 - in_a) : in_a;
    b_mag  = b_neg ? (64'd0 - in_b) : in_b;
    in_dz  = in_div && (in_b == 64'd0);
    in_ovf = in_div && in_sa && (in_b == '1) &&
             (in_a == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    in_spec = in_illegal || in_dz || in_ovf;
    // funct3[1] separates remainder from quotient among the divide ops.
    if (in_dz)       in_spec_val = funct3[1] ? in_a : '1;
    else if (in_ovf) in_spec_val = funct3[1] ? 64'd0 : in_a;
    else             in_spec_val = 64'd0;
    // Remainder takes the dividend's sign; product and quotient the XOR.
    in_neg = (in_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
  end

  assign accept    = (state == S_IDLE) && start && !flush;
  assign core_load = accept && !in_spec;

  muldiv_iter_core u_core (
    .clk    (clk),
    .rstn   (rstn),
    .load   (core_load),
    .step   ((state == S_CALC) && !flush),
    .is_div (in_div),
    .word   (word),
    .a_in   (a_mag),
    .b_in   (b_mag),
    .acc    (core_acc)
  );

  always_comb begin
    if (f3_q[2])     raw = {64'd0, f3_q[1] ? core_acc[127:64] : core_acc[63:0]};
    else if (word_q) raw = {32'd0, core_acc[127:32]};  // 32 steps leave the product at [95:32]
    else             raw = core_acc;
    hi_sel = !f3_q[2] && (f3_q != OP_MUL);
    sel    = hi_sel ? fix_q[127:64] : fix_q[63:0];
  end

  assign stall_req = rstn && ((start && (state == S_IDLE)) ||
                              (state == S_CALC) || (state == S_FIX));

  // FIX takes two cycles: sign correction of the 128-bit value, then
  // half-select and W sign-extension.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      fix_ph     <= 1'b0;
      cnt        <= '0;
      f3_q       <= '0;
      word_q     <= 1'b0;
      rd_q       <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      fix_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      rd_out     <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state  <= S_IDLE;
        busy   <= 1'b0;
        fix_ph <= 1'b0;
        cnt    <= '0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            f3_q       <= funct3;
            word_q     <= word;
            rd_q       <= rd_in;
            neg_q      <= in_neg;
            spec_q     <= in_spec;
            spec_val_q <= in_spec_val;
            cnt        <= '0;
            fix_ph     <= 1'b0;
            busy       <= 1'b1;
            state      <= in_spec ? S_FIX : S_CALC;
          end
          S_CALC: begin
            if (cnt == (word_q ? ITER_W - 7'd1 : ITER_D - 7'd1)) begin
              cnt   <= '0;
              state <= S_FIX;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
          S_FIX: begin
            if (!fix_ph) begin
              if (spec_q)     fix_q <= {64'd0, spec_val_q};
              else if (neg_q) fix_q <= 128'd0 - raw;
              else            fix_q <= raw;
              fix_ph <= 1'b1;
            end else begin
              result <= word_q ? sext32(sel[31:0]) : sel;
              rd_out <= rd_q;
              done   <= 1'b1;
              fix_ph <= 1'b0;
              state  <= S_DONE;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed vector bench for ex_muldiv
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [2:0]  funct3;
  logic        word;
  logic [63:0] rs1_val, rs2_val;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy, done, stall_req;
  logic [63:0] result;
  logic [4:0]  rd_out;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t tv[$];

  ex_muldiv dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .funct3    (funct3),
    .word      (word),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .rd_in     (rd_in),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] f3, input logic w, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] e, input int l);
    vec_t v;
    v.f3 = f3; v.w = w; v.a = a; v.b = b; v.exp = e; v.lat = l;
    tv.push_back(v);
  endtask

  // Issue one op and follow it to done. poke > 0 re-asserts start with junk
  // operands for one cycle at that point of the op; it must be ignored.
  task automatic run_op(input string nm, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp, input int lat, input int poke);
    int k;
    bit stall_ok;
    @(negedge clk);
    start = 1'b1; funct3 = f3; word = w; rs1_val = a; rs2_val = b; rd_in = rd;
    #1;
    check({nm, " stall_on_start"}, 64'(stall_req), 64'd1);
    @(posedge clk); #1;
    start = 1'b0; rs1_val = ~a; rs2_val = ~b; rd_in = ~rd;
    k = 0;
    stall_ok = 1'b1;
    while (!done && k < 200) begin
      if (k == poke && poke > 0) begin
        start = 1'b1; funct3 = 3'b000; word = 1'b0; rs1_val = 64'd3; rs2_val = 64'd3; rd_in = 5'd31;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
      if (!done && (!stall_req || !busy)) stall_ok = 1'b0;
    end
    start = 1'b0;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL %s timeout: no done after %0d cycles, want %0d", nm, k, lat);
    end else begin
      check({nm, " latency"}, 64'(k), 64'(lat));
      check({nm, " result"}, result, exp);
      check({nm, " rd_out"}, 64'(rd_out), 64'(rd));
      check({nm, " stall_busy_during_op"}, 64'(stall_ok), 64'd1);
      check({nm, " stall_at_done"}, 64'(stall_req), 64'd0);
      @(posedge clk); #1;
      check({nm, " done_one_cycle"}, 64'(done), 64'd0);
      check({nm, " busy_after"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int seen;
    rstn = 1'b0; start = 1'b0; funct3 = 3'b000; word = 1'b0;
    rs1_val = '0; rs2_val = '0; rd_in = '0; flush = 1'b0;

    //     f3      w     rs1                    rs2                    expected               lat
    add(3'b000, 1'b0, 64'h7,                 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66);
    add(3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2,                 64'h1,                   66);
    add(3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2,                 64'hFFFF_FFFF_FFFF_FFFF, 66);
    add(3'b010, 1'b0, 64'hC000_0000_0000_0000, 64'h8,                 64'hFFFF_FFFF_FFFF_FFFE, 66);
    add(3'b011, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 66);
    add(3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 66);
    add(3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                 66);
    add(3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2);
    add(3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                 2);
    add(3'b111, 1'b0, 64'h5,                 64'h0,                   64'h5,                   2);
    add(3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'h0,                 64'hFFFF_FFFF_FFFF_FFFF, 2);
    add(3'b101, 1'b0, 64'd100,               64'd7,                   64'd14,                  66);
    add(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                 64'hFFFF_FFFF_FFFF_FFFE, 66);
    add(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                 64'hFFFF_FFFF_FFFF_FFF2, 66);
    add(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                 64'hFFFF_FFFF_FFFF_FFFD, 66);
    add(3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 64'hFFFF_FFFF_FFFF_FFFF, 66);
    add(3'b111, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,                64'hF,                   66);
    add(3'b100, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,                 64'hFFFF_FFFF_FFFF_FFFD, 34);
    add(3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,                 64'hFFFF_FFFF_FFFF_FFFF, 34);
    add(3'b000, 1'b1, 64'hDEAD_0000_7FFF_FFFF, 64'd2,                 64'hFFFF_FFFF_FFFF_FFFE, 34);
    add(3'b101, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                 64'h0000_0000_7FFF_FFFC, 34);
    add(3'b111, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                 64'h1,                   34);
    add(3'b100, 1'b1, 64'h5,                 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    add(3'b110, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'h0,             2);
    add(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2);
    add(3'b011, 1'b1, 64'h5,                 64'h3,                   64'h0,                   2);

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", result, 64'd0);
    check("reset rd_out", 64'(rd_out), 64'd0);
    check("reset stall_req", 64'(stall_req), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < tv.size(); i++)
      run_op($sformatf("vec%0d", i), tv[i].f3, tv[i].w, tv[i].a, tv[i].b,
             5'(i + 1), tv[i].exp, tv[i].lat, 0);

    // Result and tag hold after done.
    repeat (5) @(posedge clk);
    #1;
    check("hold result", result, 64'h0);
    check("hold rd_out", 64'(rd_out), 64'(tv.size()));

    // start during busy is ignored; stall stays up until done.
    run_op("poke_divu", 3'b101, 1'b0, 64'd1000, 64'd33, 5'd9, 64'd30, 66, 5);
    run_op("poke_mulw", 3'b000, 1'b1, 64'd12345, 64'd1000, 5'd10, 64'd12345000, 34, 20);

    // Flush at cycle 10 of a DIVU, then a new op the following cycle.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; word = 1'b0; rs1_val = 64'd100; rs2_val = 64'd7; rd_in = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    repeat (9) begin @(posedge clk); #1; if (done) seen++; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy_next", 64'(busy), 64'd0);
    check("flush no_done", 64'(seen + int'(done)), 64'd0);
    run_op("after_flush", 3'b000, 1'b0, 64'h7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd4,
           64'hFFFF_FFFF_FFFF_FFEB, 66, 0);

    // flush beats start in the same idle cycle.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b101; rs1_val = 64'd9; rs2_val = 64'd3; rd_in = 5'd6;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_over_start busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (70) begin @(posedge clk); #1; if (done) seen++; end
    check("flush_over_start no_done", 64'(seen), 64'd0);

    // Reset pulsed mid-CALC.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; word = 1'b0; rs1_val = 64'd77; rs2_val = 64'd5; rd_in = 5'd12;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset result", result, 64'd0);
    check("midreset rd_out", 64'(rd_out), 64'd0);
    check("midreset stall_req", 64'(stall_req), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (80) begin @(posedge clk); #1; if (done || busy) seen++; end
    check("midreset no_done", 64'(seen), 64'd0);
    run_op("after_reset", 3'b100, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd7,
           64'hFFFF_FFFF_FFFF_FFFD, 34, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
